// File: rtl/power_sequencer.sv
// Parametrised N-stage power-rail sequencer: ordered ramp-up with settle/timeout,
// run-time rail supervision with latched fault, and reverse-order orderly shutdown.
module power_sequencer #(
  parameter int unsigned NUM_STAGES   = 4,
  parameter int unsigned SETTLE_DELAY = 4160000,
  parameter int unsigned GOOD_TIMEOUT = 8320000,
  parameter int unsigned ERROR_DELAY  = 8320000,
  parameter int unsigned OFF_DELAY    = 416000
) (
  input  logic                  i_clk,
  input  logic                  i_resetN,
  input  logic                  i_enable,
  input  logic                  i_clearFault,
  input  logic [NUM_STAGES-1:0] i_stageGood,
  output logic [NUM_STAGES-1:0] o_stageEnable,
  output logic                  o_allGood,
  output logic                  o_fault,
  output logic [2:0]            o_faultStage,
  output logic                  o_timeoutFault,
  output logic [2:0]            o_state
);

  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] RAMP_UP   = 3'd1;
  localparam logic [2:0] RUNNING   = 3'd2;
  localparam logic [2:0] RAMP_DOWN = 3'd3;
  localparam logic [2:0] FAULT     = 3'd4;

  localparam int unsigned MAX_AB    = (SETTLE_DELAY > GOOD_TIMEOUT) ? SETTLE_DELAY : GOOD_TIMEOUT;
  localparam int unsigned MAX_CD    = (ERROR_DELAY > OFF_DELAY) ? ERROR_DELAY : OFF_DELAY;
  localparam int unsigned MAX_DELAY = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
  localparam int unsigned TIMER_W   = $clog2(MAX_DELAY + 1);
  localparam int unsigned SETTLE_W  = $clog2(SETTLE_DELAY + 1);
  localparam int unsigned ERR_W     = $clog2(ERROR_DELAY + 1);

  localparam logic [TIMER_W-1:0]  TIMEOUT_LAST = TIMER_W'(GOOD_TIMEOUT - 1);
  localparam logic [TIMER_W-1:0]  OFF_LAST     = TIMER_W'(OFF_DELAY - 1);
  localparam logic [TIMER_W-1:0]  TIMER_MAX    = '1;
  localparam logic [SETTLE_W-1:0] SETTLE_LAST  = SETTLE_W'(SETTLE_DELAY - 1);
  localparam logic [ERR_W-1:0]    ERR_LAST     = ERR_W'(ERROR_DELAY - 1);
  localparam logic [2:0]          LAST_STAGE   = 3'(NUM_STAGES - 1);

  logic                  rstSync_p0, rstSync_p1, rstN;
  logic [NUM_STAGES-1:0] goodSync_p0, goodSync_p1;
  logic [2:0]            state, stateNext, k, kNext;
  logic [TIMER_W-1:0]    timer, timerNext;
  logic [SETTLE_W-1:0]   settleCnt, settleNext;
  logic [ERR_W-1:0]      badCnt [NUM_STAGES];
  logic [NUM_STAGES-1:0] badActive, maskNext;
  logic                  enablePrev, curGood, tripAny;
  logic [2:0]            tripIdx;
  logic                  faultNext, timeoutNext;
  logic [2:0]            faultStageNext;

  // Reset asserts asynchronously everywhere but releases on a clock edge
  always_ff @(posedge i_clk or negedge i_resetN) begin
    if (!i_resetN) begin
      rstSync_p0 <= 1'b0;
      rstSync_p1 <= 1'b0;
    end else begin
      rstSync_p0 <= 1'b1;
      rstSync_p1 <= rstSync_p0;
    end
  end
  assign rstN = rstSync_p1;

  always_ff @(posedge i_clk or negedge rstN) begin
    if (!rstN) begin
      goodSync_p0 <= '0;
      goodSync_p1 <= '0;
    end else begin
      goodSync_p0 <= i_stageGood;
      goodSync_p1 <= goodSync_p0;
    end
  end

  // Supervised stages: all of them while running, only those below k during ramp-up
  always_comb begin
    curGood   = 1'b0;
    badActive = '0;
    tripAny   = 1'b0;
    tripIdx   = 3'd0;
    for (int j = 0; j < int'(NUM_STAGES); j++) begin
      if (3'(j) == k) curGood = goodSync_p1[j];
      badActive[j] = (state == RUNNING) || ((state == RAMP_UP) && (3'(j) < k));
    end
    for (int j = int'(NUM_STAGES) - 1; j >= 0; j--) begin
      if (badActive[j] && !goodSync_p1[j] && (badCnt[j] == ERR_LAST)) begin
        tripAny = 1'b1;
        tripIdx = 3'(j);
      end
    end
  end

  always_ff @(posedge i_clk or negedge rstN) begin
    if (!rstN) begin
      for (int j = 0; j < int'(NUM_STAGES); j++) badCnt[j] <= '0;
    end else begin
      for (int j = 0; j < int'(NUM_STAGES); j++) begin
        if (badActive[j] && !goodSync_p1[j])
          badCnt[j] <= (badCnt[j] == ERR_LAST) ? badCnt[j] : badCnt[j] + 1'b1;
        else
          badCnt[j] <= '0;
      end
    end
  end

  always_comb begin
    stateNext      = state;
    kNext          = k;
    timerNext      = (timer == TIMER_MAX) ? timer : timer + 1'b1;
    settleNext     = settleCnt;
    faultNext      = o_fault;
    faultStageNext = o_faultStage;
    timeoutNext    = o_timeoutFault;
    case (state)
      IDLE: begin
        timerNext = '0;
        if (i_enable && !enablePrev) begin
          stateNext = RAMP_UP;
          kNext     = 3'd0;
        end
      end
      RAMP_UP: begin
        if (tripAny) begin
          stateNext      = FAULT;
          faultNext      = 1'b1;
          faultStageNext = tripIdx;
          timeoutNext    = 1'b0;
        end else if (!i_enable) begin
          stateNext = RAMP_DOWN;
        end else if (curGood) begin
          if (settleCnt == SETTLE_LAST) begin
            if (k == LAST_STAGE) stateNext = RUNNING;
            else                 kNext     = k + 3'd1;
          end else begin
            settleNext = settleCnt + 1'b1;
          end
        end else begin
          // A drop during settle restarts the wait; the timeout keeps running from stage enable
          settleNext = '0;
          if (timer >= TIMEOUT_LAST) begin
            stateNext      = FAULT;
            faultNext      = 1'b1;
            faultStageNext = k;
            timeoutNext    = 1'b1;
          end
        end
      end
      RUNNING: begin
        if (tripAny) begin
          stateNext      = FAULT;
          faultNext      = 1'b1;
          faultStageNext = tripIdx;
          timeoutNext    = 1'b0;
        end else if (!i_enable) begin
          stateNext = RAMP_DOWN;
        end
      end
      RAMP_DOWN: begin
        if (timer >= OFF_LAST) begin
          if (k == 3'd0) stateNext = IDLE;
          else           kNext     = k - 3'd1;
        end
      end
      FAULT: begin
        timerNext = '0;
        if (i_clearFault && !i_enable) begin
          stateNext      = IDLE;
          kNext          = 3'd0;
          faultNext      = 1'b0;
          faultStageNext = 3'd0;
          timeoutNext    = 1'b0;
        end
      end
      default: begin
        stateNext = IDLE;
        kNext     = 3'd0;
      end
    endcase
    if ((stateNext != state) || (kNext != k)) begin
      timerNext  = '0;
      settleNext = '0;
    end
  end

  // Enables are registered from the next state so the regulator pins never glitch
  always_comb begin
    maskNext = '0;
    for (int j = 0; j < int'(NUM_STAGES); j++)
      maskNext[j] = ((stateNext == RAMP_UP) || (stateNext == RUNNING) || (stateNext == RAMP_DOWN))
                    && (3'(j) <= kNext);
  end

  always_ff @(posedge i_clk or negedge rstN) begin
    if (!rstN) begin
      state          <= IDLE;
      k              <= 3'd0;
      timer          <= '0;
      settleCnt      <= '0;
      enablePrev     <= 1'b0;
      o_stageEnable  <= '0;
      o_allGood      <= 1'b0;
      o_fault        <= 1'b0;
      o_faultStage   <= 3'd0;
      o_timeoutFault <= 1'b0;
    end else begin
      state          <= stateNext;
      k              <= kNext;
      timer          <= timerNext;
      settleCnt      <= settleNext;
      enablePrev     <= i_enable;
      o_stageEnable  <= maskNext;
      o_allGood      <= (stateNext == RUNNING);
      o_fault        <= faultNext;
      o_faultStage   <= faultStageNext;
      o_timeoutFault <= timeoutNext;
    end
  end

  assign o_state = state;

endmodule
